// File: rtl/uart_stim_pkg.sv
// Shared constants and helpers for the bench-side UART 8N1 stimulus transmitter.
package uart_stim_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   typedef enum logic [1:0] {
      StIdle  = IDLE,
      StStart = START,
      StData  = DATA,
      StStop  = STOP
   } state_e;

   // Bits needed to hold 0..v-1; never less than 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_stim_fifo.sv
// Single-clock first-word-fall-through byte FIFO; dout_o shows the head while not empty.
module uart_stim_fifo
   import uart_stim_pkg::*;
#(
   parameter int unsigned FIFO_AW = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [FIFO_AW:0]  level_o
);

   localparam int unsigned Depth = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] LvlFull = (FIFO_AW + 1)'(Depth);
   localparam logic [FIFO_AW:0] LvlOne  = (FIFO_AW + 1)'(1);

   logic [DATA_W-1:0]  mem_q [Depth];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   level_q, level_d;
   logic               push_en, pop_en;

   assign full_o  = (level_q == LvlFull);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // Guard here too so a misbehaving caller cannot corrupt the pointers.
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
         2'b10:   level_d = level_q + LvlOne;
         2'b01:   level_d = level_q - LvlOne;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/uart_stim_tx.sv
// UART 8N1 stimulus transmitter: FIFO-fed serialiser driving an idle-high line at CLK_DIV
// clocks per bit, with back-to-back frames when bytes are queued.
module uart_stim_tx
   import uart_stim_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 434,
   parameter int unsigned FIFO_AW   = 4,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              tx_o,
   output logic              busy_o,
   output logic [FIFO_AW:0]  level_o
);

   localparam int unsigned CntW    = clog2(CLK_DIV);
   localparam int unsigned StopLen = STOP_BITS * CLK_DIV;
   localparam int unsigned StopW   = clog2(StopLen);
   localparam logic [CntW-1:0]  CntMax  = CntW'(CLK_DIV - 1);
   localparam logic [StopW-1:0] StopMax = StopW'(StopLen - 1);
   localparam logic [FIFO_AW:0] LvlOne  = (FIFO_AW + 1)'(1);

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [StopW-1:0]    stop_cnt_q, stop_cnt_d;
   logic [2:0]          idx_q, idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;

   logic                push, pop;
   logic                fifo_full, fifo_empty;
   logic [DATA_W-1:0]   fifo_dout;
   logic [FIFO_AW:0]    level_nxt;

   assign ready_o = !fifo_full;
   assign push    = valid_i && ready_o;
   assign tx_o    = tx_q;
   assign busy_o  = busy_q;

   uart_stim_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (data_i),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stop_cnt_d = stop_cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      pop        = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               tx_d    = 1'b0;
               cnt_d   = CntMax;
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q == '0) begin
               tx_d    = shift_q[0];
               idx_d   = '0;
               cnt_d   = CntMax;
               state_d = StData;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StData: begin
            if (cnt_q == '0) begin
               cnt_d = CntMax;
               if (idx_q == 3'd7) begin
                  tx_d       = 1'b1;
                  stop_cnt_d = '0;
                  state_d    = StStop;
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  idx_d   = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StStop: begin
            tx_d = 1'b1;
            if (stop_cnt_q == StopMax) begin
               // Chain straight into the next start bit so queued bytes leave no idle gap.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_dout;
                  tx_d    = 1'b0;
                  cnt_d   = CntMax;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // busy mirrors next-cycle state and level so it updates on the same edge as both.
   always_comb begin
      case ({push, pop})
         2'b10:   level_nxt = level_o + LvlOne;
         2'b01:   level_nxt = level_o - LvlOne;
         default: level_nxt = level_o;
      endcase
      busy_d = (state_d != StIdle) || (level_nxt != '0);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         stop_cnt_q <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stop_cnt_q <= stop_cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed bench for uart_stim_tx: three instances cover default framing, a shallow FIFO
// and two stop bits; line waveforms are compared cycle by cycle against expected frames.
module tb_uart_stim_tx;

   localparam int CDIV = 4;

   logic       clk;
   logic       rst;
   logic [7:0] data_a, data_b, data_c;
   logic       valid_a, valid_b, valid_c;
   logic       ready_a, ready_b, ready_c;
   logic       tx_a, tx_b, tx_c;
   logic       busy_a, busy_b, busy_c;
   logic [4:0] level_a;
   logic [2:0] level_b;
   logic [4:0] level_c;

   int         n_checks;
   int         n_errors;
   logic [7:0] fr_q [$];
   logic [7:0] b_bytes [7];

   uart_stim_tx #(.CLK_DIV(CDIV), .FIFO_AW(4), .STOP_BITS(1)) u_dut_a (
      .wb_clk_i (clk), .wb_rst_i (rst), .data_i (data_a), .valid_i (valid_a),
      .ready_o (ready_a), .tx_o (tx_a), .busy_o (busy_a), .level_o (level_a)
   );

   uart_stim_tx #(.CLK_DIV(CDIV), .FIFO_AW(2), .STOP_BITS(1)) u_dut_b (
      .wb_clk_i (clk), .wb_rst_i (rst), .data_i (data_b), .valid_i (valid_b),
      .ready_o (ready_b), .tx_o (tx_b), .busy_o (busy_b), .level_o (level_b)
   );

   uart_stim_tx #(.CLK_DIV(CDIV), .FIFO_AW(4), .STOP_BITS(2)) u_dut_c (
      .wb_clk_i (clk), .wb_rst_i (rst), .data_i (data_c), .valid_i (valid_c),
      .ready_o (ready_c), .tx_o (tx_c), .busy_o (busy_c), .level_o (level_c)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   // Expected line level k cycles after the first start bit, for back-to-back frames in fr_q.
   function automatic logic exp_bit(input int k, input int sb);
      int flen, f, pos;
      flen = (9 + sb) * CDIV;
      f    = k / flen;
      pos  = (k % flen) / CDIV;
      if (f >= fr_q.size()) return 1'b1;
      if (pos == 0) return 1'b0;
      if (pos <= 8) return fr_q[f][pos-1];
      return 1'b1;
   endfunction

   function automatic logic tx_of(input int sel);
      case (sel)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_wave(input int sel, input int k0, input int k1, input int sb);
      for (int k = k0; k < k1; k++) begin
         check($sformatf("wave%0d_k%0d", sel, k), 32'(tx_of(sel)), 32'(exp_bit(k, sb)));
         tick();
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      valid_a  = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
      data_a   = '0;   data_b  = '0;   data_c  = '0;
      b_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h81};

      // Reset and idle.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         check("idle_tx", 32'(tx_a), 32'd1);
         check("idle_ready", 32'(ready_a), 32'd1);
         check("idle_busy", 32'(busy_a), 32'd0);
         check("idle_level", 32'(level_a), 32'd0);
         tick();
      end
      check("idle_ready_b", 32'(ready_b), 32'd1);
      check("idle_tx_c", 32'(tx_c), 32'd1);

      // Single byte 0xA5.
      fr_q = '{8'hA5};
      @(negedge clk);
      data_a = 8'hA5; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      check("a5_level_push", 32'(level_a), 32'd1);
      check("a5_tx_pre", 32'(tx_a), 32'd1);
      check("a5_busy_push", 32'(busy_a), 32'd1);
      tick();
      check("a5_level_pop", 32'(level_a), 32'd0);
      run_wave(0, 0, 39, 1);
      check("a5_busy_last", 32'(busy_a), 32'd1);
      tick();
      check("a5_busy_end", 32'(busy_a), 32'd0);
      check("a5_tx_end", 32'(tx_a), 32'd1);

      // Back-to-back 0x00, 0xFF, 0x55.
      fr_q = '{8'h00, 8'hFF, 8'h55};
      @(negedge clk);
      data_a = 8'h00; valid_a = 1'b1;
      tick();
      check("b2b_level0", 32'(level_a), 32'd1);
      data_a = 8'hFF;
      tick();
      check("b2b_level1", 32'(level_a), 32'd1);
      check("b2b_k0", 32'(tx_a), 32'(exp_bit(0, 1)));
      data_a = 8'h55;
      tick();
      valid_a = 1'b0;
      check("b2b_level_peak", 32'(level_a), 32'd2);
      check("b2b_k1", 32'(tx_a), 32'(exp_bit(1, 1)));
      tick();
      run_wave(0, 2, 119, 1);
      check("b2b_busy_last", 32'(busy_a), 32'd1);
      tick();
      check("b2b_busy_end", 32'(busy_a), 32'd0);
      check("b2b_level_end", 32'(level_a), 32'd0);

      // Shallow FIFO filled while a frame is on the line.
      fr_q = '{};
      for (int i = 0; i < 7; i++) fr_q.push_back(b_bytes[i]);
      @(negedge clk);
      data_b = b_bytes[0]; valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      tick();
      fork
         begin
            run_wave(1, 0, 280, 1);
         end
         begin
            int  got;
            int  budget;
            logic acc;
            got    = 1;
            budget = 0;
            while (got < 7 && budget < 400) begin
               data_b  = b_bytes[got];
               valid_b = 1'b1;
               acc     = ready_b;
               tick();
               budget++;
               if (acc) begin
                  got++;
                  if (got == 5) begin
                     check("fifo_full_level", 32'(level_b), 32'd4);
                     check("fifo_full_ready", 32'(ready_b), 32'd0);
                  end
               end
            end
            valid_b = 1'b0;
            check("fifo_all_pushed", 32'(got), 32'd7);
         end
      join
      check("fifo_busy_end", 32'(busy_b), 32'd0);
      check("fifo_level_end", 32'(level_b), 32'd0);

      // Two stop bits, 0x3C.
      fr_q = '{8'h3C};
      @(negedge clk);
      data_c = 8'h3C; valid_c = 1'b1;
      tick();
      valid_c = 1'b0;
      tick();
      run_wave(2, 0, 43, 2);
      check("stop2_busy_last", 32'(busy_c), 32'd1);
      check("stop2_tx_last", 32'(tx_c), 32'd1);
      tick();
      check("stop2_busy_end", 32'(busy_c), 32'd0);

      // Reset during data bit 3 with two bytes queued.
      fr_q = '{8'h00, 8'h0F, 8'hF0};
      @(negedge clk);
      data_a = 8'h00; valid_a = 1'b1;
      tick();
      data_a = 8'h0F;
      tick();
      data_a = 8'hF0;
      tick();
      valid_a = 1'b0;
      check("rst_level_pre", 32'(level_a), 32'd2);
      tick();
      run_wave(0, 2, 18, 1);
      check("rst_tx_bit3", 32'(tx_a), 32'd0);
      check("rst_level_mid", 32'(level_a), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_level", 32'(level_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_ready", 32'(ready_a), 32'd1);
      for (int i = 0; i < 100; i++) begin
         tick();
         check("post_rst_tx", 32'(tx_a), 32'd1);
         check("post_rst_busy", 32'(busy_a), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_stim_tx.md
Name: uart_stim_tx

Overview:
- Bench-side UART 8N1 transmitter that drives the SoC's uart0_srx_pad_i. It is the upstream counterpart of the UART decoder watching uart0_stx_pad_o.
- Test sequences push bytes through a valid/ready interface into an internal FIFO. The block serialises them at a fixed baud derived from the 50 MHz system clock.
- Written as synthesizable RTL, so it can also be used as an on-board loopback stimulus.

Parameters:
- CLK_DIV, 434: clock cycles per bit (50 MHz / 115200 ≈ 434, matches the 8680 ns decoder period); legal range 2..65535.
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW entries.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- wb_clk_i  in  1  system clock; all state changes on its rising edge.
- wb_rst_i  in  1  synchronous reset, active-high.
- data_i  in  8  byte to send.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  FIFO can accept a byte; a push occurs when valid_i && ready_o at a clock edge.
- tx_o  out  1  serial line to uart0_srx_pad_i; idle high.
- busy_o  out  1  high when a frame is in progress or the FIFO is non-empty.
- level_o  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.

Behaviour:
- Reset (wb_rst_i sampled high at an edge) sets: tx_o=1, ready_o=1, busy_o=0, level_o=0, state=IDLE, baud counter=0, FIFO pointers=0.
- Reset mid-frame aborts the frame. tx_o returns high on the next edge. FIFO contents are discarded.
- ready_o = !full. It is registered-equivalent, derived only from FIFO level, with no combinational path from valid_i.
- No push is ever accepted while full. There is no overflow condition.
- Push and pop on the same edge leaves level_o unchanged.
- FSM states and transitions:
  - IDLE: tx_o=1. If the FIFO is non-empty: pop the head into shift register, tx_o<=0, cnt<=CLK_DIV-1, go to START.
  - START: when cnt==0: tx_o<=shift[0], bit index<=0, cnt<=CLK_DIV-1, go to DATA. Otherwise cnt--.
  - DATA: data is sent LSB first. When cnt==0: if index==7, tx_o<=1, stop counter<=0, go to STOP; else shift right, tx_o<=next bit, index++. cnt reloads CLK_DIV-1 on each bit.
  - STOP: tx_o=1 for STOP_BITS*CLK_DIV cycles. At the end: if the FIFO is non-empty, pop and go directly to START with tx_o<=0 (no idle gap); else go to IDLE.
- Every bit, including start and stop, is exactly CLK_DIV cycles on tx_o.
- Frame length is (9+STOP_BITS)*CLK_DIV cycles.
- Latency: a byte pushed at edge N into an empty FIFO with FSM in IDLE pops at edge N+1. tx_o falls at edge N+1.
- busy_o = (state!=IDLE) || (level_o!=0). It is registered and updated on the same edge as the state and level.
- Counter widths: cnt is ceil(log2(CLK_DIV)) bits; index is 3 bits. No arithmetic wraps beyond reload.

Decomposition:
- Package uart_stim_pkg holds:
  - state encoding localparams IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - the 8-bit data width constant;
  - the clog2 helper function.
- Sub-module uart_stim_fifo: synchronous single-clock FIFO.
  - Parameter FIFO_AW.
  - Ports: push/pop/din/dout/full/empty/level.
  - First-word-fall-through: dout shows the head while !empty.
  - Same reset rules as above.
- The top level contains the FSM, baud counter and shift register.

Test Plan:
- Reset then idle 100 cycles -> tx_o=1, ready_o=1, busy_o=0, level_o=0 throughout.
- CLK_DIV=4, push 0xA5 at edge N -> tx_o low from edge N+1 for 4 cycles. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. busy_o drops at edge N+41.
- CLK_DIV=4, push 0x00,0xFF,0x55 back-to-back -> three contiguous 40-cycle frames, no idle gap. level_o peaks at 2 (first byte already popped).
- FIFO_AW=2, FSM stalled mid-frame, push 6 bytes with valid_i held -> exactly 4 accepted after the pop (level_o=4, ready_o=0). Remaining pushes wait; all bytes transmitted in order with none lost.
- STOP_BITS=2, CLK_DIV=4, push 0x3C -> stop high for 8 cycles; total frame 44 cycles.
- Assert wb_rst_i during DATA bit 3 of a frame with 2 bytes queued -> next edge tx_o=1, level_o=0. No further frames are sent until a new push.
